// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int STREAK_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/RAM bus of the memory-port arbiter; slave = arbiter side, master = environment side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              flush;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata, mem_q,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_addr, mem_wren, mem_wdata
  );

  modport master (
    output if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata, mem_q,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_addr, mem_wren, mem_wdata
  );
endinterface

// File: rtl/mem_arb_streak.sv
// Anti-starvation counter: counts data grants while a fetch waits and forces a fetch grant at the limit.
module mem_arb_streak
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_if_gnt,
  input  logic i_dm_gnt,
  output logic o_force
);

  logic [2:0] r_streak;
  logic [2:0] w_streak_nxt;

  // Saturating streak update; cleared whenever the fetch side is served or gives up.
  always_comb begin
    w_streak_nxt = r_streak;
    if (i_if_gnt || !i_if_req) begin
      w_streak_nxt = 3'd0;
    end else if (i_dm_gnt && (r_streak != 3'd7)) begin
      w_streak_nxt = r_streak + 3'd1;
    end else begin
      w_streak_nxt = r_streak;
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= 3'd0;
    end else begin
      r_streak <= w_streak_nxt;
    end
  end

  assign o_force = i_if_req && (r_streak >= 3'(STREAK_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and LDR/STR data accesses.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = STREAK_MAX_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t        r_state;
  owner_t            r_owner;
  logic              r_squash;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  arb_state_t        w_state_nxt;
  owner_t            w_owner_nxt;
  logic              w_squash_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_if_gnt;
  logic              w_dm_gnt;
  logic              w_wren;
  logic              w_if_rvalid;
  logic              w_dm_rvalid;
  logic              w_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_streak #(
    .STREAK_MAX (STREAK_MAX)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (bus.if_req),
    .i_if_gnt (w_if_gnt),
    .i_dm_gnt (w_dm_gnt),
    .o_force  (w_force)
  );
`else
  assign w_force = 1'b0;
`endif

  // Arbitration, RAM drive and read-return routing.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_squash_nxt = r_squash;
    w_addr_nxt   = r_mem_addr;
    w_wdata_nxt  = r_mem_wdata;
    w_if_gnt     = 1'b0;
    w_dm_gnt     = 1'b0;
    w_wren       = 1'b0;
    w_if_rvalid  = 1'b0;
    w_dm_rvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        // Grants are held off while reset is asserted so outputs read as reset values.
        if (rst) begin
          w_state_nxt = IDLE;
        end else if (bus.dm_req && !w_force) begin
          w_dm_gnt    = 1'b1;
          w_wren      = bus.dm_we;
          w_addr_nxt  = bus.dm_addr;
          w_wdata_nxt = bus.dm_wdata;
          if (!bus.dm_we) begin
            w_state_nxt  = RD_WAIT;
            w_owner_nxt  = OWN_DM;
            w_squash_nxt = 1'b0;
          end else begin
            w_state_nxt  = IDLE;
          end
        end else if (bus.if_req) begin
          w_if_gnt     = 1'b1;
          w_addr_nxt   = bus.if_addr;
          w_state_nxt  = RD_WAIT;
          w_owner_nxt  = OWN_IF;
          w_squash_nxt = bus.flush;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        // A flush arriving in the return cycle squashes the fetch as well.
        if (r_owner == OWN_IF) begin
          w_if_rvalid = !r_squash && !bus.flush;
        end else begin
          w_dm_rvalid = 1'b1;
        end
        w_state_nxt  = IDLE;
        w_squash_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_squash_nxt = 1'b0;
      end
    endcase
  end

  // Arbiter state and held RAM address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_squash    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_squash    <= w_squash_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dm_rvalid = w_dm_rvalid;
  assign bus.if_rdata  = bus.mem_q;
  assign bus.dm_rdata  = bus.mem_q;
  assign bus.mem_addr  = w_addr_nxt;
  assign bus.mem_wren  = w_wren;
  assign bus.mem_wdata = w_wdata_nxt;

endmodule
